// File: rtl/lsu_pkg.sv
// Shared LSU definitions: datapath widths, RV32I load/store funct3 codes, FSM states, captured request.
package lsu_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned NLANES = XLEN / 8;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_WAIT = 2'b10,
        ST_DONE = 2'b11
    } lsu_state_e;

    typedef struct packed {
        logic            we;
        logic [2:0]      funct3;
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] wdata;
    } lsu_req_t;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: fault decode, store strobes/replication, load lane select and extension.
module lsu_align
    import lsu_pkg::*;
(
    input  logic              we_i,
    input  logic [2:0]        funct3_i,
    input  logic [1:0]        addr_lo_i,
    input  logic [XLEN-1:0]   wdata_i,
    input  logic [XLEN-1:0]   rdata_i,
    output logic              fault_o,
    output logic [NLANES-1:0] wstrb_o,
    output logic [XLEN-1:0]   wdata_o,
    output logic [XLEN-1:0]   rdata_o
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // Illegal funct3 or misaligned half/word access
    always_comb begin
        fault_o = 1'b0;
        case (funct3_i)
            F3_B:    fault_o = 1'b0;
            F3_H:    fault_o = addr_lo_i[0];
            F3_W:    fault_o = |addr_lo_i;
            F3_BU:   fault_o = we_i;
            F3_HU:   fault_o = we_i | addr_lo_i[0];
            default: fault_o = 1'b1;
        endcase
    end

    // Store strobes and lane-replicated write data
    always_comb begin
        wstrb_o = '0;
        wdata_o = wdata_i;
        case (funct3_i)
            F3_B: begin
                wdata_o = {NLANES{wdata_i[7:0]}};
                if (we_i) wstrb_o = NLANES'(1) << addr_lo_i;
            end
            F3_H: begin
                wdata_o = {2{wdata_i[15:0]}};
                if (we_i) wstrb_o = NLANES'(3) << {addr_lo_i[1], 1'b0};
            end
            F3_W: begin
                if (we_i) wstrb_o = '1;
            end
            default: wstrb_o = '0;
        endcase
    end

    // Load lane select followed by sign/zero extension
    always_comb begin
        ld_byte = rdata_i[7:0];
        case (addr_lo_i)
            2'd0: ld_byte = rdata_i[7:0];
            2'd1: ld_byte = rdata_i[15:8];
            2'd2: ld_byte = rdata_i[23:16];
            2'd3: ld_byte = rdata_i[31:24];
            default: ld_byte = rdata_i[7:0];
        endcase
        ld_half = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        case (funct3_i)
            F3_B:    rdata_o = {{24{ld_byte[7]}}, ld_byte};
            F3_H:    rdata_o = {{16{ld_half[15]}}, ld_half};
            F3_BU:   rdata_o = {24'd0, ld_byte};
            F3_HU:   rdata_o = {16'd0, ld_half};
            default: rdata_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit: captures one access, runs it over the valid/ready bus and returns extended load data.
module lsu
    import lsu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              lsu_req_ip,
    input  logic              lsu_we_ip,
    input  logic [2:0]        lsu_funct3_ip,
    input  logic [XLEN-1:0]   lsu_addr_ip,
    input  logic [XLEN-1:0]   lsu_wdata_ip,
    output logic              lsu_busy_op,
    output logic              lsu_done_op,
    output logic              lsu_fault_op,
    output logic [XLEN-1:0]   lsu_rdata_op,
    output logic              mem_valid_op,
    input  logic              mem_ready_ip,
    output logic              mem_we_op,
    output logic [XLEN-1:0]   mem_addr_op,
    output logic [NLANES-1:0] mem_wstrb_op,
    output logic [XLEN-1:0]   mem_wdata_op,
    input  logic              mem_rvalid_ip,
    input  logic [XLEN-1:0]   mem_rdata_ip
);

    lsu_state_e        state_q, state_d;
    lsu_req_t          req_q, req_d;
    logic              done_q, done_d;
    logic              fault_q, fault_d;
    logic [XLEN-1:0]   rdata_q, rdata_d;

    logic              sel_we;
    logic [2:0]        sel_funct3;
    logic [1:0]        sel_addr_lo;
    logic [XLEN-1:0]   sel_wdata;
    logic              al_fault;
    logic [NLANES-1:0] al_wstrb;
    logic [XLEN-1:0]   al_wdata;
    logic [XLEN-1:0]   al_rdata;

    // Lane logic sees the incoming request while idle so faults resolve in the capture cycle
    always_comb begin
        if (state_q == ST_IDLE) begin
            sel_we      = lsu_we_ip;
            sel_funct3  = lsu_funct3_ip;
            sel_addr_lo = lsu_addr_ip[1:0];
            sel_wdata   = lsu_wdata_ip;
        end else begin
            sel_we      = req_q.we;
            sel_funct3  = req_q.funct3;
            sel_addr_lo = req_q.addr[1:0];
            sel_wdata   = req_q.wdata;
        end
    end

    lsu_align u_align (
        .we_i      (sel_we),
        .funct3_i  (sel_funct3),
        .addr_lo_i (sel_addr_lo),
        .wdata_i   (sel_wdata),
        .rdata_i   (mem_rdata_ip),
        .fault_o   (al_fault),
        .wstrb_o   (al_wstrb),
        .wdata_o   (al_wdata),
        .rdata_o   (al_rdata)
    );

    // State and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            req_q   <= '0;
            done_q  <= 1'b0;
            fault_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            done_q  <= done_d;
            fault_q <= fault_d;
            rdata_q <= rdata_d;
        end
    end

    // Next-state logic; bus handshakes only matter in their own state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (lsu_req_ip) state_d = al_fault ? ST_DONE : ST_REQ;
            ST_REQ:  if (mem_ready_ip) state_d = ST_WAIT;
            ST_WAIT: if (mem_rvalid_ip) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Capture, completion results and bus drive
    always_comb begin
        req_d        = req_q;
        done_d       = 1'b0;
        fault_d      = 1'b0;
        rdata_d      = rdata_q;
        mem_valid_op = 1'b0;
        mem_we_op    = 1'b0;
        mem_addr_op  = '0;
        mem_wstrb_op = '0;
        mem_wdata_op = '0;
        case (state_q)
            ST_IDLE: begin
                if (lsu_req_ip) begin
                    req_d = '{we: lsu_we_ip, funct3: lsu_funct3_ip,
                              addr: lsu_addr_ip, wdata: lsu_wdata_ip};
                    if (al_fault) begin
                        done_d  = 1'b1;
                        fault_d = 1'b1;
                        rdata_d = '0;
                    end
                end
            end
            ST_REQ: begin
                mem_valid_op = 1'b1;
                mem_we_op    = req_q.we;
                mem_addr_op  = {req_q.addr[XLEN-1:2], 2'b00};
                mem_wstrb_op = al_wstrb;
                mem_wdata_op = al_wdata;
            end
            ST_WAIT: begin
                if (mem_rvalid_ip) begin
                    done_d  = 1'b1;
                    rdata_d = req_q.we ? '0 : al_rdata;
                end
            end
            default: ;
        endcase
    end

    assign lsu_busy_op  = ((state_q == ST_IDLE) & lsu_req_ip)
                        | (state_q == ST_REQ) | (state_q == ST_WAIT);
    assign lsu_done_op  = done_q;
    assign lsu_fault_op = fault_q;
    assign lsu_rdata_op = rdata_q;

endmodule

// File: tb/tb_lsu.sv
// Randomised self-checking bench for lsu against a behavioural access model.
module tb_lsu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        lsu_req_ip;
    logic        lsu_we_ip;
    logic [2:0]  lsu_funct3_ip;
    logic [31:0] lsu_addr_ip;
    logic [31:0] lsu_wdata_ip;
    logic        lsu_busy_op;
    logic        lsu_done_op;
    logic        lsu_fault_op;
    logic [31:0] lsu_rdata_op;
    logic        mem_valid_op;
    logic        mem_ready_ip;
    logic        mem_we_op;
    logic [31:0] mem_addr_op;
    logic [3:0]  mem_wstrb_op;
    logic [31:0] mem_wdata_op;
    logic        mem_rvalid_ip;
    logic [31:0] mem_rdata_ip;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    lsu dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .lsu_req_ip    (lsu_req_ip),
        .lsu_we_ip     (lsu_we_ip),
        .lsu_funct3_ip (lsu_funct3_ip),
        .lsu_addr_ip   (lsu_addr_ip),
        .lsu_wdata_ip  (lsu_wdata_ip),
        .lsu_busy_op   (lsu_busy_op),
        .lsu_done_op   (lsu_done_op),
        .lsu_fault_op  (lsu_fault_op),
        .lsu_rdata_op  (lsu_rdata_op),
        .mem_valid_op  (mem_valid_op),
        .mem_ready_ip  (mem_ready_ip),
        .mem_we_op     (mem_we_op),
        .mem_addr_op   (mem_addr_op),
        .mem_wstrb_op  (mem_wstrb_op),
        .mem_wdata_op  (mem_wdata_op),
        .mem_rvalid_ip (mem_rvalid_ip),
        .mem_rdata_ip  (mem_rdata_ip)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        else n_pass++;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_valid"}, 32'(mem_valid_op), 32'd0);
        check({tag, "_done"},  32'(lsu_done_op),  32'd0);
        check({tag, "_fault"}, 32'(lsu_fault_op), 32'd0);
        check({tag, "_rdata"}, lsu_rdata_op,      32'd0);
        check({tag, "_busy"},  32'(lsu_busy_op),  32'd0);
        check({tag, "_we"},    32'(mem_we_op),    32'd0);
        check({tag, "_addr"},  mem_addr_op,       32'd0);
        check({tag, "_wstrb"}, 32'(mem_wstrb_op), 32'd0);
        check({tag, "_wdata"}, mem_wdata_op,      32'd0);
    endtask

    // One complete access: cycle 0 request, optional bus stalls, then the done cycle
    task automatic run_access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [31:0] rword,
                              input int rdy_dly, input int rv_dly);
        bit          legal, flt;
        int          size, off;
        logic [31:0] exp_addr, exp_wd, exp_rd, word;
        logic [3:0]  exp_strb;
        longint      val;

        // Reference model straight from the access rules
        legal = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        size  = 1 << f3[1:0];
        off   = int'(addr % 4);
        flt   = !legal || ((addr % size) != 0);
        exp_addr = addr & ~32'h3;
        exp_strb = 4'd0;
        exp_wd   = 32'd0;
        exp_rd   = 32'd0;
        if (we) begin
            exp_strb = 4'(((1 << size) - 1) << off);
            for (int i = 0; i < 4; i++) exp_wd[8*i +: 8] = wdata[8*(i % size) +: 8];
        end else if (!flt) begin
            word = rword >> (8 * off);
            if (size == 4) exp_rd = word;
            else begin
                val = longint'(word) & ((64'd1 << (8 * size)) - 1);
                if (!f3[2] && val >= (64'd1 << (8 * size - 1))) val = val - (64'd1 << (8 * size));
                exp_rd = val[31:0];
            end
        end

        @(negedge clk);
        lsu_req_ip = 1'b1; lsu_we_ip = we; lsu_funct3_ip = f3;
        lsu_addr_ip = addr; lsu_wdata_ip = wdata;
        mem_ready_ip = 1'b0; mem_rvalid_ip = 1'($urandom); mem_rdata_ip = $urandom;
        #1;
        check("c0_busy",  32'(lsu_busy_op),  32'd1);
        check("c0_done",  32'(lsu_done_op),  32'd0);
        check("c0_valid", 32'(mem_valid_op), 32'd0);

        if (flt) begin
            @(negedge clk);
            lsu_req_ip = 1'($urandom); lsu_addr_ip = $urandom; mem_ready_ip = 1'($urandom);
            #1;
            check("flt_done",  32'(lsu_done_op),  32'd1);
            check("flt_fault", 32'(lsu_fault_op), 32'd1);
            check("flt_rdata", lsu_rdata_op,      32'd0);
            check("flt_valid", 32'(mem_valid_op), 32'd0);
            check("flt_busy",  32'(lsu_busy_op),  32'd0);
        end else begin
            for (int c = 0; c <= rdy_dly; c++) begin
                @(negedge clk);
                lsu_req_ip = 1'($urandom); lsu_we_ip = 1'($urandom); lsu_addr_ip = $urandom;
                lsu_funct3_ip = 3'($urandom); lsu_wdata_ip = $urandom;
                mem_ready_ip = (c == rdy_dly); mem_rvalid_ip = 1'($urandom); mem_rdata_ip = $urandom;
                #1;
                check("req_valid", 32'(mem_valid_op), 32'd1);
                check("req_we",    32'(mem_we_op),    32'(we));
                check("req_addr",  mem_addr_op,       exp_addr);
                check("req_wstrb", 32'(mem_wstrb_op), 32'(exp_strb));
                if (we) check("req_wdata", mem_wdata_op, exp_wd);
                check("req_busy",  32'(lsu_busy_op),  32'd1);
                check("req_done",  32'(lsu_done_op),  32'd0);
            end
            for (int c = 0; c <= rv_dly; c++) begin
                @(negedge clk);
                lsu_req_ip = 1'($urandom);
                mem_ready_ip = 1'($urandom); mem_rvalid_ip = (c == rv_dly);
                mem_rdata_ip = (c == rv_dly) ? rword : $urandom;
                #1;
                check("wait_valid", 32'(mem_valid_op), 32'd0);
                check("wait_busy",  32'(lsu_busy_op),  32'd1);
                check("wait_done",  32'(lsu_done_op),  32'd0);
            end
            @(negedge clk);
            lsu_req_ip = 1'($urandom); mem_rvalid_ip = 1'($urandom); mem_rdata_ip = $urandom;
            #1;
            check("done_done",  32'(lsu_done_op),  32'd1);
            check("done_fault", 32'(lsu_fault_op), 32'd0);
            check("done_rdata", lsu_rdata_op,      exp_rd);
            check("done_busy",  32'(lsu_busy_op),  32'd0);
            check("done_valid", 32'(mem_valid_op), 32'd0);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        lsu_req_ip = 1'b0; lsu_we_ip = 1'b0; lsu_funct3_ip = 3'd0;
        lsu_addr_ip = 32'd0; lsu_wdata_ip = 32'd0;
        mem_ready_ip = 1'b0; mem_rvalid_ip = 1'b0; mem_rdata_ip = 32'd0;
        repeat (2) @(negedge clk);
        #1;
        check_idle_outputs("rst");
        @(negedge clk);
        rst_n = 1'b1;

        // Directed cases
        run_access(1'b0, 3'b010, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 0, 0);
        run_access(1'b0, 3'b000, 32'h0000_0103, 32'h0, 32'h80FF_0000, 0, 0);
        run_access(1'b0, 3'b100, 32'h0000_0103, 32'h0, 32'h80FF_0000, 0, 0);
        run_access(1'b1, 3'b001, 32'h0000_0202, 32'h1234_ABCD, 32'h5555_5555, 0, 0);
        run_access(1'b0, 3'b010, 32'h0000_0101, 32'h0, 32'h0, 0, 0);
        run_access(1'b1, 3'b011, 32'h0000_0100, 32'hFFFF_FFFF, 32'h0, 0, 0);
        run_access(1'b0, 3'b010, 32'h0000_0300, 32'h0, 32'hCAFE_F00D, 5, 3);
        run_access(1'b0, 3'b101, 32'h0000_0012, 32'h0, 32'h9ABC_0000, 1, 1);
        run_access(1'b1, 3'b000, 32'h0000_0011, 32'h0000_00A5, 32'h0, 2, 0);

        // Reset during WAIT abandons the access; a late response is dropped
        @(negedge clk);
        lsu_req_ip = 1'b1; lsu_we_ip = 1'b0; lsu_funct3_ip = 3'b010;
        lsu_addr_ip = 32'h0000_0040; mem_ready_ip = 1'b0; mem_rvalid_ip = 1'b0;
        @(negedge clk);
        lsu_req_ip = 1'b0; mem_ready_ip = 1'b1;
        @(negedge clk);
        mem_ready_ip = 1'b0;
        #1;
        check("rwait_busy", 32'(lsu_busy_op), 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_idle_outputs("rst_wait");
        @(negedge clk);
        rst_n = 1'b1; mem_rvalid_ip = 1'b1; mem_rdata_ip = $urandom;
        @(negedge clk);
        mem_rvalid_ip = 1'b0;
        #1;
        check("late_done",  32'(lsu_done_op),  32'd0);
        check("late_busy",  32'(lsu_busy_op),  32'd0);
        check("late_valid", 32'(mem_valid_op), 32'd0);
        run_access(1'b0, 3'b010, 32'h0000_0044, 32'h0, 32'h0BAD_F00D, 0, 0);

        // Random accesses, biased towards legal function codes
        for (int n = 0; n < 200; n++) begin
            logic        we;
            logic [2:0]  f3;
            logic [31:0] addr;
            we   = 1'($urandom);
            f3   = ($urandom_range(0, 7) == 0) ? 3'($urandom) : 3'($urandom_range(0, 5));
            addr = $urandom;
            if ($urandom_range(0, 1) == 1) addr[1:0] = 2'b00;
            run_access(we, f3, addr, $urandom, $urandom, $urandom_range(0, 3), $urandom_range(0, 3));
        end

        @(negedge clk);
        lsu_req_ip = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
